// File: rtl/temp_ram_arbiter_if.sv
// Bus bundle between the temperature RAM arbiter, its two requesters and the RAM macro.
// The arbiter takes the slave modport and the requester/RAM side takes the master modport.
interface temp_ram_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ovf;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    output rd_data, rd_valid, rd_ovf, wr_gnt, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    input  rd_data, rd_valid, rd_ovf, wr_gnt, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/temp_ram_arbiter.sv
// Read-priority arbiter for the single-port 128x8 temperature RAM with write anti-starvation.
// Define ARB_STATS_EN to add saturating read/write/forced-write counters as extra outputs.
module temp_ram_arbiter #(
  parameter int AW          = 7,
  parameter int DW          = 8,
  parameter int WR_MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ARB_STATS_EN
  output logic [15:0]          rd_cnt,
  output logic [15:0]          wr_cnt,
  output logic [7:0]           starve_hits,
`endif
  temp_ram_arbiter_if.slave    bus
);

  localparam logic [7:0] MAX_W = 8'(WR_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    RD_CAP = 2'd2,
    WR     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_ovf_q, rd_ovf_d;
  logic [7:0]    starve_q, starve_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic          wr_gnt_q, wr_gnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_grant_s;
  logic          wr_grant_s;

  // Grant decision, RAM port drive, read capture and starvation tracking
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    rd_ovf_d    = rd_ovf_q;
    starve_d    = starve_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_gnt_d    = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_grant_s  = 1'b0;
    wr_grant_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wr_req && (starve_q == MAX_W)) begin
          state_d    = WR;
          wr_grant_s = 1'b1;
        end else if (rd_pend_q || bus.rd_req) begin
          state_d    = RD;
          rd_grant_s = 1'b1;
        end else if (bus.wr_req) begin
          state_d    = WR;
          wr_grant_s = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      RD:     state_d = RD_CAP;
      RD_CAP: begin
        state_d    = IDLE;
        rd_data_d  = bus.ram_rdata;
        rd_valid_d = 1'b1;
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // RAM port outputs are registered, so they are loaded on the granting edge
    if (rd_grant_s) begin
      ram_addr_d = rd_pend_q ? rd_addr_q : bus.rd_addr;
    end else if (wr_grant_s) begin
      ram_addr_d  = bus.wr_addr;
      ram_wdata_d = bus.wr_data;
      ram_we_d    = 1'b1;
      wr_gnt_d    = 1'b1;
    end else begin
      ram_addr_d  = ram_addr_q;
    end

    if (bus.rd_req) begin
      if (rd_pend_q && !rd_grant_s) begin
        rd_ovf_d = 1'b1;
      end else if (rd_pend_q || !rd_grant_s) begin
        rd_pend_d = 1'b1;
        rd_addr_d = bus.rd_addr;
      end else begin
        rd_pend_d = 1'b0;
      end
    end else if (rd_grant_s) begin
      rd_pend_d = 1'b0;
    end else begin
      rd_pend_d = rd_pend_q;
    end

    if (wr_grant_s) begin
      starve_d = 8'd0;
    end else if (bus.wr_req && (state_q != WR) && (starve_q != MAX_W)) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers; reset drops any in-flight transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= {AW{1'b0}};
      rd_ovf_q    <= 1'b0;
      starve_q    <= 8'd0;
      ram_addr_q  <= {AW{1'b0}};
      ram_wdata_q <= {DW{1'b0}};
      ram_we_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      rd_data_q   <= {DW{1'b0}};
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      rd_ovf_q    <= rd_ovf_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wr_gnt_q    <= wr_gnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_ovf    = rd_ovf_q;
  assign bus.wr_gnt    = wr_gnt_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;

`ifdef ARB_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]  starve_hits_q, starve_hits_d;
  logic        forced_s;

  assign forced_s = wr_grant_s && (starve_q == MAX_W);

  // Saturating event counters
  always_comb begin
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    starve_hits_d = starve_hits_q;
    if (rd_valid_d && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (wr_grant_s && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (forced_s && (starve_hits_q != 8'hFF)) begin
      starve_hits_d = starve_hits_q + 8'd1;
    end else begin
      starve_hits_d = starve_hits_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q      <= 16'd0;
      wr_cnt_q      <= 16'd0;
      starve_hits_q <= 8'd0;
    end else begin
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      starve_hits_q <= starve_hits_d;
    end
  end

  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;
  assign starve_hits = starve_hits_q;
`endif

endmodule

// File: tb/tb_temp_ram_arbiter.sv
// Directed self-checking bench for temp_ram_arbiter with a behavioural 128x8 synchronous RAM.
module tb_temp_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  temp_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [7:0]  starve_hits;
`endif

  temp_ram_arbiter #(.AW(AW), .DW(DW), .WR_MAX_WAIT(15)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ARB_STATS_EN
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
    .starve_hits (starve_hits),
`endif
    .bus         (bus)
  );

  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    chk("wr_gnt", bus.wr_gnt, 1);
    chk("wr_ram_we", bus.ram_we, 1);
    chk("wr_ram_addr", bus.ram_addr, a);
    chk("wr_ram_wdata", bus.ram_wdata, d);
    bus.wr_req = 1'b0;
    step();
    chk("wr_gnt_pulse", bus.wr_gnt, 0);
    chk("wr_ram_we_off", bus.ram_we, 0);
    chk("ram_addr_hold", bus.ram_addr, a);
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    step();
    bus.rd_req = 1'b0;
    chk("rd_ram_addr", bus.ram_addr, a);
    chk("rd_ram_we", bus.ram_we, 0);
    step();
    chk("rd_valid_early", bus.rd_valid, 0);
    step();
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_data", bus.rd_data, exp);
    step();
    chk("rd_valid_pulse", bus.rd_valid, 0);
  endtask

  // Starvation scenario: reads every 3 cycles against a held write; extra adds a read in the WR cycle
  task automatic run_starve(input bit extra);
    int gnt_j;
    int rv_total;
    int rv_after;
    gnt_j    = -1;
    rv_total = 0;
    rv_after = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 7'h22;
    bus.wr_data = 8'h33;
    bus.rd_addr = 7'h05;
    for (int j = 0; j < 30; j++) begin
      bus.rd_req = (((j % 3) == 0) && (j <= 15)) || (extra && (j == 16));
      step();
      if (bus.rd_valid) begin
        rv_total++;
        if (gnt_j >= 0) rv_after++;
        chk("starve_rd_data", bus.rd_data, 8'hA7);
      end
      if (bus.wr_gnt && (gnt_j < 0)) begin
        gnt_j = j;
        bus.wr_req = 1'b0;
        chk("starve_cleared", dut.starve_q, 0);
        chk("starve_wr_addr", bus.ram_addr, 7'h22);
      end
    end
    bus.rd_req = 1'b0;
    chk("starve_gnt_in_time", (gnt_j >= 0) && (gnt_j <= 16), 1);
    chk("starve_rd_total", rv_total, 6);
    chk("starve_rd_after_wr", rv_after, 1);
    chk("starve_ovf", bus.rd_ovf, extra);
  endtask

  typedef struct {
    bit         is_wr;
    logic [6:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int rv_at;
    int wg_at;
    int rv_seen;

    vecs[0] = '{1'b1, 7'h00, 8'h11};
    vecs[1] = '{1'b1, 7'h7F, 8'hFE};
    vecs[2] = '{1'b1, 7'h10, 8'h5A};
    vecs[3] = '{1'b1, 7'h40, 8'h55};
    vecs[4] = '{1'b0, 7'h00, 8'h11};
    vecs[5] = '{1'b0, 7'h7F, 8'hFE};
    vecs[6] = '{1'b0, 7'h40, 8'h55};
    vecs[7] = '{1'b1, 7'h40, 8'hAA};
    vecs[8] = '{1'b0, 7'h40, 8'hAA};
    vecs[9] = '{1'b0, 7'h10, 8'h5A};

    bus.rd_req  = 1'b0;
    bus.rd_addr = 7'h00;
    bus.wr_req  = 1'b0;
    bus.wr_addr = 7'h00;
    bus.wr_data = 8'h00;
    step();
    step();
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_ovf", bus.rd_ovf, 0);
    chk("rst_wr_gnt", bus.wr_gnt, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    rst = 1'b1;
    step();

    do_write(7'h05, 8'hA7);
    do_read(7'h05, 8'hA7);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else do_read(vecs[i].addr, vecs[i].data);
    end

    // Contention: read and write on the same edge
    rv_at = -1;
    wg_at = -1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 7'h10;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 7'h11;
    bus.wr_data = 8'h99;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) bus.rd_req = 1'b0;
      if (bus.rd_valid && (rv_at < 0)) begin
        rv_at = i;
        chk("cont_rd_data", bus.rd_data, 8'h5A);
      end
      if (bus.wr_gnt && (wg_at < 0)) begin
        wg_at = i;
        bus.wr_req = 1'b0;
        chk("cont_wr_addr", bus.ram_addr, 7'h11);
      end
    end
    chk("cont_rd_first", rv_at, 3);
    chk("cont_wr_second", wg_at, 4);
    chk("cont_ovf", bus.rd_ovf, 0);
    do_read(7'h11, 8'h99);

    run_starve(1'b0);
    run_starve(1'b1);
    step();
    step();
    do_read(7'h05, 8'hA7);
    chk("ovf_sticky", bus.rd_ovf, 1);

    // Reset asserted during the RD_CAP cycle
    bus.rd_req  = 1'b1;
    bus.rd_addr = 7'h7F;
    step();
    bus.rd_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    chk("mid_rst_rd_data", bus.rd_data, 0);
    chk("mid_rst_rd_ovf", bus.rd_ovf, 0);
    chk("mid_rst_ram_addr", bus.ram_addr, 0);
    chk("mid_rst_ram_wdata", bus.ram_wdata, 0);
    chk("mid_rst_ram_we", bus.ram_we, 0);
    step();
    step();
    rst = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.rd_valid) rv_seen++;
    end
    chk("mid_rst_no_valid", rv_seen, 0);
    chk("mid_rst_ovf_clear", bus.rd_ovf, 0);

`ifdef ARB_STATS_EN
    chk("stats_rst_rd", rd_cnt, 0);
    do_read(7'h00, 8'h11);
    do_read(7'h7F, 8'hFE);
    do_read(7'h40, 8'hAA);
    do_write(7'h01, 8'h01);
    do_write(7'h02, 8'h02);
    chk("stats_rd_cnt", rd_cnt, 3);
    chk("stats_wr_cnt", wr_cnt, 2);
    chk("stats_starve_hits0", starve_hits, 0);
    run_starve(1'b0);
    chk("stats_starve_hits1", starve_hits, 1);
    chk("stats_wr_cnt_forced", wr_cnt, 3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
